// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Autonomous animation engine for the 8-bit LED PIO. An Avalon-MM master
// periodically writes a pattern into the PIO data register (offset 0). The
// engine is configured through a small Avalon-MM CSR slave. The PIO remains
// the only driver of the LEDs.
//
// Ports
//   clk, reset_n         system clock; asynchronous active-low reset
//   csr_address[1:0]     CSR word select (0 CTRL, 1 PERIOD, 2 STATIC, 3 STATUS)
//   csr_chipselect       CSR select
//   csr_write_n          CSR write strobe, active-low
//   csr_writedata[31:0]  CSR write data
//   csr_readdata[31:0]   CSR read data, combinational, zero wait states
//   m_address[1:0]       PIO address, always 0
//   m_chipselect         master request
//   m_write_n            master write strobe, active-low
//   m_writedata[31:0]    {24'b0, pattern}
//   m_waitrequest        slave stall
//   busy                 high while the sequencer is not idle
//
// CSR map
//   0 CTRL    bit0 EN, bits2:1 MODE (0 walk, 1 bounce, 2 count, 3 static)
//   1 PERIOD  [CNT_W-1:0] clk cycles between ticks; 0 is stored as 1
//   2 STATIC  [7:0] pattern used by static mode
//   3 STATUS  read-only: bit0 busy, bits15:8 current pattern
//
// Build option
//   LED_SEQ_BLANK_ON_DISABLE_EN: when defined, clearing EN issues one extra
//   write of 0x00 (LEDs blanked) before returning to idle. When undefined the
//   LEDs keep the last pattern.
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 50000000,
  parameter int LED_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_address,
  input  logic        csr_chipselect,
  input  logic        csr_write_n,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  localparam logic [1:0] MODE_WALK   = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STATIC = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

`ifdef LED_SEQ_BLANK_ON_DISABLE_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, WAIT_TICK, BLANK} state_t;
  // Where the engine goes once it has been disabled: through one blank write.
  localparam state_t STOP_STATE = BLANK;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, WAIT_TICK} state_t;
  localparam state_t STOP_STATE = IDLE;
`endif

  state_t state_q;
  state_t state_d;

  // Configuration registers
  logic             ctrl_en;
  logic [1:0]       ctrl_mode;
  logic [CNT_W-1:0] period_q;
  logic [LED_W-1:0] static_q;

  // Animation state
  logic [LED_W-1:0] pattern_q;
  logic             dir_right_q;  // bounce direction, 0 = moving left
  logic [1:0]       run_mode_q;   // mode the current pattern belongs to
  logic [CNT_W-1:0] count_q;

  // FSM strobes into the datapath
  logic do_load;
  logic do_tick;
  logic do_dec;

  logic csr_wr;
  logic en_set;
  logic unused_wdata;

  assign csr_wr = csr_chipselect & ~csr_write_n;
  // EN being written to 1 this very cycle; lets a completing write go
  // straight back to LOAD instead of idling.
  assign en_set = csr_wr & (csr_address == ADDR_CTRL) & csr_writedata[0];

  assign unused_wdata = ^csr_writedata[31:CNT_W];

  assign m_address = 2'b00;
  assign busy      = (state_q != IDLE);

  // First pattern of a mode.
  function automatic logic [LED_W-1:0] init_pattern(
    input logic [1:0]       mode,
    input logic [LED_W-1:0] stat
  );
    logic [LED_W-1:0] r;
    case (mode)
      MODE_WALK:   r = LED_W'(1);
      MODE_BOUNCE: r = LED_W'(1);
      MODE_COUNT:  r = '0;
      default:     r = stat;
    endcase
    return r;
  endfunction

  // Next {dir_right, pattern} for one tick within the same mode.
  function automatic logic [LED_W:0] advance_pattern(
    input logic [1:0]       mode,
    input logic [LED_W-1:0] pat,
    input logic             dir_right,
    input logic [LED_W-1:0] stat
  );
    logic [LED_W:0] r;
    r = {dir_right, pat};
    case (mode)
      MODE_WALK: r = {dir_right, pat[LED_W-2:0], pat[LED_W-1]};
      MODE_BOUNCE: begin
        // Reverse on reaching an end so the endpoint is shown only once.
        if (!dir_right) begin
          if (pat[LED_W-1]) r = {1'b1, pat >> 1};
          else              r = {1'b0, pat << 1};
        end else begin
          if (pat[0]) r = {1'b0, pat << 1};
          else        r = {1'b1, pat >> 1};
        end
      end
      MODE_COUNT: r = {dir_right, pat + LED_W'(1)};
      default:    r = {dir_right, stat};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and master outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    do_load      = 1'b0;
    do_tick      = 1'b0;
    do_dec       = 1'b0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    case (state_q)
      IDLE: begin
        if (ctrl_en) state_d = LOAD;
      end
      LOAD: begin
        do_load = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = {{(32-LED_W){1'b0}}, pattern_q};
        // The request is held unchanged until the slave accepts it; the
        // period counter stays frozen meanwhile.
        if (!m_waitrequest) begin
          if (ctrl_en)     state_d = WAIT_TICK;
          else if (en_set) state_d = LOAD;
          else             state_d = STOP_STATE;
        end
      end
      WAIT_TICK: begin
        if (!ctrl_en) begin
          state_d = STOP_STATE;
        end else if (count_q == '0) begin
          do_tick = 1'b1;
          state_d = WRITE;
        end else begin
          do_dec = 1'b1;
        end
      end
`ifdef LED_SEQ_BLANK_ON_DISABLE_EN
      BLANK: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = '0;
        if (!m_waitrequest) begin
          if (ctrl_en || en_set) state_d = LOAD;
          else                   state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CSR registers, pattern generator and period counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_mode   <= MODE_WALK;
      period_q    <= CNT_W'(DEFAULT_PERIOD);
      static_q    <= '0;
      pattern_q   <= '0;
      dir_right_q <= 1'b0;
      run_mode_q  <= MODE_WALK;
      count_q     <= '0;
    end else begin
      if (csr_wr) begin
        case (csr_address)
          ADDR_CTRL: begin
            ctrl_en   <= csr_writedata[0];
            ctrl_mode <= csr_writedata[2:1];
          end
          ADDR_PERIOD: begin
            // A zero period would never tick; clamp it to one cycle.
            if (csr_writedata[CNT_W-1:0] == '0) period_q <= CNT_W'(1);
            else                                period_q <= csr_writedata[CNT_W-1:0];
          end
          ADDR_STATIC: static_q <= csr_writedata[LED_W-1:0];
          default: ;
        endcase
      end

      if (do_load) begin
        pattern_q   <= init_pattern(ctrl_mode, static_q);
        dir_right_q <= 1'b0;
        run_mode_q  <= ctrl_mode;
        count_q     <= period_q - CNT_W'(1);
      end else if (do_tick) begin
        // PERIOD edits only take effect here, at a reload.
        count_q    <= period_q - CNT_W'(1);
        run_mode_q <= ctrl_mode;
        if (ctrl_mode != run_mode_q) begin
          // Mode switched while running: restart the new animation.
          pattern_q   <= init_pattern(ctrl_mode, static_q);
          dir_right_q <= 1'b0;
        end else begin
          {dir_right_q, pattern_q} <= advance_pattern(ctrl_mode, pattern_q,
                                                      dir_right_q, static_q);
        end
      end else if (do_dec) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CSR read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_readdata = '0;
    case (csr_address)
      ADDR_CTRL:   csr_readdata = {29'd0, ctrl_mode, ctrl_en};
      ADDR_PERIOD: csr_readdata = {{(32-CNT_W){1'b0}}, period_q};
      ADDR_STATIC: csr_readdata = {{(32-LED_W){1'b0}}, static_q};
      ADDR_STATUS: csr_readdata = {16'd0, pattern_q, 7'd0, busy};
      default:     csr_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

  localparam int DEF_PERIOD = 50000000;
`ifdef LED_SEQ_BLANK_ON_DISABLE_EN
  localparam int BLANK_EXTRA = 1;
`else
  localparam int BLANK_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  csr_address = 2'd0;
  logic        csr_chipselect = 1'b0;
  logic        csr_write_n = 1'b1;
  logic [31:0] csr_writedata = 32'd0;
  logic [31:0] csr_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        busy;

  led_pattern_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_chipselect (csr_chipselect),
    .csr_write_n    (csr_write_n),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .m_address      (m_address),
    .m_chipselect   (m_chipselect),
    .m_write_n      (m_write_n),
    .m_writedata    (m_writedata),
    .m_waitrequest  (m_waitrequest),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit rand_stall = 1'b0;

  // Accepted-write log: data, cycle stamp and stall cycles before acceptance.
  logic [31:0] acc_data[$];
  int          acc_cyc[$];
  int          acc_stall[$];
  int          cyc = 0;
  int          stall_run = 0;
  int          unstable = 0;
  bit          held = 1'b0;
  logic [31:0] held_data = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        stall_run = 0;
        held = 1'b0;
      end else if (m_chipselect && !m_write_n) begin
        if (held && (m_writedata !== held_data || m_address !== 2'b00)) unstable++;
        if (m_waitrequest) begin
          stall_run++;
          held = 1'b1;
          held_data = m_writedata;
        end else begin
          acc_data.push_back(m_writedata);
          acc_cyc.push_back(cyc);
          acc_stall.push_back(stall_run);
          stall_run = 0;
          held = 1'b0;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference patterns computed directly from the animation rules.
  function automatic logic [31:0] walk_val(input int k);
    return 32'(1) << (k % 8);
  endfunction

  function automatic logic [31:0] bounce_val(input int k);
    int m;
    int pos;
    m = k % 14;
    pos = (m < 8) ? m : 14 - m;
    return 32'(1) << pos;
  endfunction

  function automatic logic [31:0] count_val(input int k);
    return 32'(k % 256);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_stall) m_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    csr_address = a;
    csr_writedata = d;
    csr_chipselect = 1'b1;
    csr_write_n = 1'b0;
    tick();
    csr_chipselect = 1'b0;
    csr_write_n = 1'b1;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    csr_address = a;
    #1;
    d = csr_readdata;
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (acc_data.size() < n && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_timeout"}, 32'(acc_data.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t;
    t = 0;
    while (busy && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_strobe(input int budget, input string tag);
    int t;
    t = 0;
    while (!m_chipselect && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_strobe"}, 32'(m_chipselect), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    int n0;
    int pb;
    int n_pat;

    // Reset state
    tick(); tick(); tick();
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_wn", 32'(m_write_n), 32'd1);
    check("rst_wd", m_writedata, 32'd0);
    check("rst_addr", 32'(m_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    csr_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);
    csr_read(2'd1, rd); check("rst_period", rd, 32'(DEF_PERIOD));
    csr_read(2'd2, rd); check("rst_static", rd, 32'd0);
    csr_read(2'd3, rd); check("rst_status", rd, 32'd0);

    // Walk, PERIOD=4: one write every 5 cycles
    csr_write(2'd1, 32'd4);
    csr_write(2'd0, 32'h1);
    wait_acc(10, 200, "walk");
    for (int k = 0; k < 10; k++) begin
      check($sformatf("walk_data[%0d]", k), acc_data[k], walk_val(k));
      if (k > 0) check($sformatf("walk_gap[%0d]", k), acc_cyc[k] - acc_cyc[k-1], 32'd5);
    end

    // Switch to bounce while running, with a random new period
    pb = $urandom_range(2, 5);
    csr_write(2'd1, 32'(pb));
    csr_write(2'd0, 32'h3);
    wait_acc(31, 600, "bounce");
    check("mode_switch_gap", acc_cyc[10] - acc_cyc[9], 32'd5);
    for (int k = 0; k < 21; k++) begin
      check($sformatf("bounce_data[%0d]", k), acc_data[10+k], bounce_val(k));
      if (k > 0) check($sformatf("bounce_gap[%0d]", k), acc_cyc[10+k] - acc_cyc[9+k], 32'(pb + 1));
    end
    csr_write(2'd0, 32'h0);
    wait_idle(50, "bounce_off");
    repeat (10) tick();
    check("bounce_off_writes", 32'(acc_data.size()), 32'(31 + BLANK_EXTRA));
    if (BLANK_EXTRA != 0) check("bounce_blank", acc_data[acc_data.size()-1], 32'd0);
    csr_read(2'd3, rd);
    check("bounce_status_pat", {24'd0, rd[15:8]}, bounce_val(20));

    // Count, PERIOD=1, random slave stalls
    base = acc_data.size();
    csr_write(2'd1, 32'd1);
    csr_write(2'd0, 32'h5);
    rand_stall = 1'b1;
    wait_acc(base + 258, 3000, "count");
    csr_read(2'd3, rd);
    check("count_status_busy", 32'(rd[0]), 32'd1);
    rand_stall = 1'b0;
    m_waitrequest = 1'b0;
    csr_write(2'd0, 32'h4);
    wait_idle(50, "count_off");
    n_pat = acc_data.size() - base - BLANK_EXTRA;
    for (int k = 0; k < n_pat; k++) begin
      check($sformatf("count_data[%0d]", k), acc_data[base+k], count_val(k));
      if (k > 0) check($sformatf("count_gap[%0d]", k), acc_cyc[base+k] - acc_cyc[base+k-1],
                       32'(2 + acc_stall[base+k]));
    end
    csr_read(2'd3, rd);
    check("count_status_pat", {24'd0, rd[15:8]}, count_val(n_pat - 1));
    check("count_status_busy_off", 32'(rd[0]), 32'd0);

    // Static with a 10-cycle stall on the first write
    base = acc_data.size();
    csr_write(2'd2, 32'hA5);
    csr_write(2'd1, 32'd3);
    m_waitrequest = 1'b1;
    csr_write(2'd0, 32'h7);
    wait_strobe(20, "stall");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall_cs[%0d]", i), 32'(m_chipselect), 32'd1);
      check($sformatf("stall_wn[%0d]", i), 32'(m_write_n), 32'd0);
      check($sformatf("stall_addr[%0d]", i), 32'(m_address), 32'd0);
      check($sformatf("stall_wd[%0d]", i), m_writedata, 32'hA5);
      tick();
    end
    check("stall_no_accept", 32'(acc_data.size()), 32'(base));
    m_waitrequest = 1'b0;
    tick();
    check("stall_one_accept", 32'(acc_data.size()), 32'(base + 1));
    check("stall_cs_drop", 32'(m_chipselect), 32'd0);
    check("stall_count", 32'(acc_stall[base]), 32'd10);
    wait_acc(base + 2, 50, "static2");
    check("static_data0", acc_data[base], 32'hA5);
    check("static_data1", acc_data[base+1], 32'hA5);
    check("stall_frozen_gap", acc_cyc[base+1] - acc_cyc[base], 32'd4);
    csr_write(2'd2, 32'h3C);
    wait_acc(base + 3, 50, "static3");
    check("static_data2", acc_data[base+2], 32'h3C);
    check("static_gap2", acc_cyc[base+2] - acc_cyc[base+1], 32'd4);
    check("stall_unstable", 32'(unstable), 32'd0);
    csr_write(2'd1, 32'd0);
    csr_read(2'd1, rd);
    check("period_zero_clamp", rd, 32'd1);

    // Clear EN during a stalled write
    m_waitrequest = 1'b1;
    wait_strobe(20, "dis");
    csr_write(2'd0, 32'h6);
    tick(); tick();
    check("dis_busy_stalled", 32'(busy), 32'd1);
    check("dis_cs_stalled", 32'(m_chipselect), 32'd1);
    n0 = acc_data.size();
    m_waitrequest = 1'b0;
    tick();
    check("dis_accept", 32'(acc_data.size()), 32'(n0 + 1));
    check("dis_data", acc_data[acc_data.size()-1], 32'h3C);
`ifdef LED_SEQ_BLANK_ON_DISABLE_EN
    check("dis_blank_busy", 32'(busy), 32'd1);
    check("dis_blank_cs", 32'(m_chipselect), 32'd1);
    check("dis_blank_wd", m_writedata, 32'd0);
    tick();
    check("dis_blank_accept", 32'(acc_data.size()), 32'(n0 + 2));
    check("dis_blank_data", acc_data[acc_data.size()-1], 32'd0);
`endif
    check("dis_busy_fall", 32'(busy), 32'd0);
    n0 = acc_data.size();
    repeat (20) tick();
    check("dis_no_more", 32'(acc_data.size()), 32'(n0));
    check("dis_busy_low", 32'(busy), 32'd0);

    // Unused CTRL bits read 0; STATUS is read-only
    csr_write(2'd0, 32'hFFFF_FFF6);
    csr_read(2'd0, rd); check("ctrl_unused", rd, 32'h6);
    csr_write(2'd3, 32'hFFFF_FFFF);
    csr_read(2'd3, rd); check("status_ro", rd, 32'h3C00);
    csr_write(2'd2, 32'hFFFF_FF5A);
    csr_read(2'd2, rd); check("static_unused", rd, 32'h5A);

    // Reset in the middle of a stalled write
    m_waitrequest = 1'b1;
    csr_write(2'd0, 32'h7);
    wait_strobe(20, "rstmid");
    reset_n = 1'b0;
    #1;
    check("rstmid_cs", 32'(m_chipselect), 32'd0);
    check("rstmid_wn", 32'(m_write_n), 32'd1);
    check("rstmid_wd", m_writedata, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    csr_read(2'd0, rd); check("rstmid_ctrl", rd, 32'd0);
    csr_read(2'd1, rd); check("rstmid_period", rd, 32'(DEF_PERIOD));
    csr_read(2'd3, rd); check("rstmid_status", rd, 32'd0);
    m_waitrequest = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Autonomous pattern engine for the 8-bit LED PIO.
- Avalon-MM master that periodically writes the PIO data register at offset 0, so the LEDs animate without HPS/Nios intervention.
- Configured through its own small Avalon-MM CSR slave.
- Sits between the Qsys interconnect and the LED PIO slave. The PIO remains the only LED driver.

Parameters:
- CNT_W, 26: width of the period counter and the PERIOD register.
- DEFAULT_PERIOD, 50000000: reset value of PERIOD in clk cycles (1 s at 50 MHz).
- LED_W, 8: pattern width. Fixed at 8; other values are unsupported.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- csr_address  in  2  CSR word select
- csr_chipselect  in  1  CSR select
- csr_write_n  in  1  CSR write strobe, active-low
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, combinational, zero wait states
- m_address  out  2  PIO address, always 0
- m_chipselect  out  1  master request
- m_write_n  out  1  master write strobe, active-low
- m_writedata  out  32  {24'b0, pattern}
- m_waitrequest  in  1  slave stall; tie 0 for the plain PIO
- busy  out  1  high while enabled or while a write is in flight

Behaviour:
- Reset: all regs clear asynchronously.
  - Outputs: m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0, busy=0.
  - Registers: CTRL=0, PERIOD=DEFAULT_PERIOD, STATIC=0, pattern=0, FSM=IDLE.
- CSR map (write = chipselect & ~write_n). Reads of unused bits return 0.
  - 0 CTRL: bit0 EN; bits2:1 MODE (0 walk, 1 bounce, 2 count, 3 static).
  - 1 PERIOD: [CNT_W-1:0]. A write of 0 is stored as 1.
  - 2 STATIC: [7:0].
  - 3 STATUS, read-only: bit0 busy, bits15:8 current pattern. Writes are ignored.
- FSM states: IDLE, LOAD, WRITE, WAIT_TICK.
  - IDLE -> LOAD: on EN=1.
  - LOAD, 1 cycle: pattern <= initial value for MODE (walk 0x01, bounce 0x01 with dir=left, count 0x00, static STATIC). Counter <= PERIOD-1. Go to WRITE.
  - WRITE: m_chipselect=1, m_write_n=0, m_writedata={24'b0,pattern}.
    - Held stable while m_waitrequest=1.
    - Write is accepted on a cycle with m_waitrequest=0; deassert on the next cycle.
    - After acceptance go to WAIT_TICK, or to IDLE if EN=0.
  - WAIT_TICK: counter decrements by 1 per cycle.
    - At 0: reload PERIOD-1, advance pattern, go to WRITE.
    - Tick-to-write latency is 1 cycle, so the write period is PERIOD plus the write duration.
- Pattern advance:
  - walk: rotate left; 0x80 -> 0x01.
  - bounce: shift in dir. At 0x80 dir becomes right (next 0x40). At 0x01 dir becomes left (next 0x02).
  - count: +1 mod 256; 0xFF -> 0x00.
  - static: reload from STATIC, so STATIC edits appear at the next tick.
- Counter is frozen during WRITE. Ticks are never queued.
- PERIOD written while running: takes effect at the next reload.
- MODE changed while enabled: at the next tick, pattern is set to the new mode's initial value instead of advancing.
- EN cleared:
  - In WAIT_TICK: go to IDLE next cycle.
  - In WRITE: the current write completes, then IDLE. An accepted write is never aborted.
  - The pattern register retains its last value.
- EN set in the same cycle the last write completes: go to LOAD, not IDLE.
- Reset mid-write: master signals drop immediately (asynchronous). Integration accepts a lost write.
- busy = (state != IDLE).

Optional Feature:
- Macro: LED_SEQ_BLANK_ON_DISABLE_EN.
- Defined:
  - On EN 1->0, after any in-flight write completes, one extra WRITE with m_writedata=0 is issued (LEDs blanked), then IDLE.
  - busy stays high until that blank write is accepted.
  - Re-enable during the blank write proceeds to LOAD after acceptance.
- Undefined: no blank write. The LEDs keep the last pattern.

Test Plan:
- Reset, then PERIOD=4, CTRL=0x1 (walk), waitrequest=0 -> writes 0x01, 0x02, 0x04, ... 0x80, 0x01. Consecutive write strobes are 5 cycles apart.
- CTRL=0x3 (bounce), PERIOD=2 -> write sequence 0x01, 0x02, ... 0x80, 0x40, ... 0x01, 0x02. No repeated endpoint values.
- CTRL=0x5 (count) for 257 ticks -> writes 0x00..0xFF, then 0x00. STATUS[15:8] matches the last written value.
- m_waitrequest held high 10 cycles during a write -> address/data/strobes stable throughout, exactly one accept, and the counter does not decrement during the stall.
- CTRL=0x7 (static), STATIC=0xA5, then STATIC=0x3C mid-period -> writes 0xA5, then 0x3C at the next tick. A PERIOD write of 0 reads back as 1.
- Clear EN during a stalled write -> the write completes, busy falls 1 cycle after acceptance, and no further writes occur. With LED_SEQ_BLANK_ON_DISABLE_EN, one additional write of 0x00 precedes busy falling.
